// File: rtl/mdc_commutator_scheduler_if.sv
// Handshake/status bundle for the MDC commutator scheduler.
// SCHED_STATS_EN adds the frame/underrun statistics signals.
interface mdc_commutator_scheduler_if #(
   parameter int NUM_STAGES = 3
);
   logic                  enable;
   logic                  in_valid;
   logic [NUM_STAGES-1:0] switch_sel;
   logic [NUM_STAGES-1:0] stage_valid;
   logic                  frame_done;
   logic                  busy;
   logic                  underrun;
`ifdef SCHED_STATS_EN
   logic [15:0]           frame_count;
   logic [7:0]            underrun_count;

   modport master (
      output enable, in_valid,
      input  switch_sel, stage_valid, frame_done, busy, underrun,
      input  frame_count, underrun_count
   );
   modport slave (
      input  enable, in_valid,
      output switch_sel, stage_valid, frame_done, busy, underrun,
      output frame_count, underrun_count
   );
`else
   modport master (
      output enable, in_valid,
      input  switch_sel, stage_valid, frame_done, busy, underrun
   );
   modport slave (
      input  enable, in_valid,
      output switch_sel, stage_valid, frame_done, busy, underrun
   );
`endif
endinterface

// File: rtl/mdc_commutator_scheduler.sv
// Sequences the delay-commutator stages of a radix-2 MDC FFT pipeline.
// Define SCHED_STATS_EN to add the frame_count / underrun_count statistics outputs.
module mdc_commutator_scheduler #(
   parameter  int LOG2_N     = 4,
   localparam int NUM_STAGES = LOG2_N - 1
) (
   input  logic                          clk,
   input  logic                          reset,
   mdc_commutator_scheduler_if.slave     bus
);
   localparam int HALF   = 2 ** (LOG2_N - 1);
   localparam int LAT    = HALF - 1;
   localparam int SAMP_W = LOG2_N - 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [SAMP_W-1:0]   samp_q, samp_d;
   logic [SAMP_W-1:0]   drain_q, drain_d;
   logic                pend_q, pend_d;
   logic                done_q, done_d;
   logic                under_q, under_d;
   logic                busy_q, busy_d;
   logic                last_sample;
   logic                drop;

   logic [NUM_STAGES-1:0] v_in;
   logic [NUM_STAGES-1:0] sel_w;
   logic [NUM_STAGES-1:0] sv_w;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      drain_d     = drain_q;
      done_d      = 1'b0;
      under_d     = 1'b0;
      last_sample = bus.in_valid && (state_q == ST_RUN) && (samp_q == SAMP_W'(HALF - 1));
      drop        = (state_q == ST_RUN) && !bus.in_valid && (samp_q != '0);
      // Sample index of the next accepted pair; wraps to 0 at a frame boundary.
      samp_d      = bus.in_valid ? samp_q + SAMP_W'(1) : '0;

      // The drain register holds the remaining latency minus one, so the
      // pulse lands on the cycle the last pair leaves the final stage.
      if (pend_q) begin
         if (drain_q != '0) begin
            drain_d = drain_q - SAMP_W'(1);
         end else begin
            pend_d = 1'b0;
         end
         done_d = (drain_q == SAMP_W'(1));
      end
      if (last_sample) begin
         pend_d  = 1'b1;
         drain_d = SAMP_W'(LAT - 1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.in_valid) state_d = (samp_q == '0) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (bus.in_valid)                   state_d = ST_RUN;
            else if (pend_q && drain_q == '0)   state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (drop) begin
         under_d = 1'b1;
         pend_d  = 1'b0;
         drain_d = '0;
         done_d  = 1'b0;
         samp_d  = '0;
      end
      busy_d = (state_d != ST_IDLE) || pend_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         samp_q  <= '0;
         drain_q <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (bus.enable) begin
         state_q <= state_d;
         samp_q  <= samp_d;
         drain_q <= drain_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         under_q <= under_d;
         busy_q  <= busy_d;
      end
   end

   assign v_in = {sv_w[NUM_STAGES-2:0], bus.in_valid};

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int D  = 2 ** (NUM_STAGES - 1 - gi);
      localparam int CW = NUM_STAGES - gi;

      logic [CW-1:0] cnt_q, cnt_d;
      logic [D-1:0]  dly_q, dly_d;
      logic          sel_q;

      // Counter is modulo 2*D, so its MSB is exactly "count >= D".
      assign cnt_d = v_in[gi] ? cnt_q + CW'(1) : cnt_q;

      if (D > 1) begin : g_shift
         assign dly_d = {dly_q[D-2:0], v_in[gi]};
      end else begin : g_single
         assign dly_d = v_in[gi];
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
            dly_q <= '0;
            sel_q <= 1'b0;
         end else if (bus.enable) begin
            if (drop) begin
               cnt_q <= '0;
               dly_q <= '0;
               sel_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               dly_q <= dly_d;
               sel_q <= cnt_d[CW-1];
            end
         end
      end

      assign sel_w[gi] = sel_q;
      assign sv_w[gi]  = dly_q[D-1];
   end

   assign bus.switch_sel  = sel_w;
   assign bus.stage_valid = sv_w;
   assign bus.frame_done  = done_q;
   assign bus.underrun    = under_q;
   assign bus.busy        = busy_q;

`ifdef SCHED_STATS_EN
   logic [15:0] frame_count_q;
   logic [7:0]  underrun_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_count_q    <= '0;
         underrun_count_q <= '0;
      end else if (bus.enable) begin
         if (done_d) frame_count_q <= frame_count_q + 16'd1;
         if (under_d && underrun_count_q != 8'hFF) underrun_count_q <= underrun_count_q + 8'd1;
      end
   end

   assign bus.frame_count    = frame_count_q;
   assign bus.underrun_count = underrun_count_q;
`endif
endmodule
